// File: rtl/game_pkg.sv
// Shared constants for the square game: FSM encodings, the seconds-counter width
// and the terminal second count.
package game_pkg;

  localparam int SEC_W        = 11;
  localparam int GAME_MAX_SEC = 180;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

  // Three decimal digits of the elapsed-seconds display.
  typedef struct packed {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
  } bcd3_t;

  // Ripple a +1 through the three digits. Ones 9->0 carries into tens,
  // tens 9->0 carries into hundreds.
  function automatic bcd3_t bcd_inc(input bcd3_t b);
    bcd3_t r;
    r = b;
    if (b.o == 4'd9) begin
      r.o = 4'd0;
      if (b.t == 4'd9) begin
        r.t = 4'd0;
        r.h = b.h + 4'd1;
      end else begin
        r.t = b.t + 4'd1;
      end
    end else begin
      r.o = b.o + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchroniser plus rising-edge detector. Turns a slow asynchronous
// square wave into a single-cycle tick in the clk domain. The tick is seen in
// the cycle after the second synchroniser flop goes high, so a consumer that
// registers on the tick updates on the 3rd clk edge after the input rises.
module tick_sync (
  input  logic clk,
  input  logic rst,      // active-low, asynchronous
  input  logic async_in,
  output logic tick
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Shift the input through the synchroniser and the edge-history flop.
  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser and edge-history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Rising edge only; falling edges never produce a tick.
  assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/game_timer.sv
// Elapsed-game-time counter. Counts whole seconds from the 1 Hz input while
// running, keeps a BCD copy of the count for the 7-seg scanner, and pulses
// time_up in the cycle the terminal count is reached.
module game_timer #(
  parameter int SEC_W   = game_pkg::SEC_W,
  parameter int MAX_SEC = game_pkg::GAME_MAX_SEC
) (
  input  logic             clk,
  input  logic             rst,      // active-low, asynchronous
  input  logic             clk_1hz,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [SEC_W-1:0] sec,
  output logic [3:0]       bcd_h,
  output logic [3:0]       bcd_t,
  output logic [3:0]       bcd_o,
  output logic [1:0]       state,
  output logic             running,
  output logic             time_up
);

  import game_pkg::game_state_e;
  import game_pkg::bcd3_t;
  import game_pkg::bcd_inc;

  localparam logic [SEC_W-1:0] MAX_SEC_V = SEC_W'(MAX_SEC);

  logic tick;

  game_state_e      state_q,   state_d;
  logic [SEC_W-1:0] sec_q,     sec_d;
  bcd3_t            bcd_q,     bcd_d;
  logic             running_q, running_d;
  logic             time_up_q, time_up_d;

  tick_sync u_tick_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (clk_1hz),
    .tick     (tick)
  );

  // Next-state logic: clear beats pause beats start beats tick. The seconds
  // counter and the digit chain always step together so they never disagree.
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    bcd_d     = bcd_q;
    time_up_d = 1'b0;
    if (clear) begin
      state_d = game_pkg::ST_IDLE;
      sec_d   = '0;
      bcd_d   = '0;
    end else begin
      unique case (state_q)
        game_pkg::ST_IDLE: begin
          if (start) state_d = game_pkg::ST_RUN;
        end
        game_pkg::ST_RUN: begin
          if (pause) begin
            state_d = game_pkg::ST_PAUSE;           // a coincident tick is dropped
          end else if (tick && (sec_q < MAX_SEC_V)) begin
            sec_d = sec_q + SEC_W'(1);
            bcd_d = bcd_inc(bcd_q);
            if (sec_d == MAX_SEC_V) begin
              state_d   = game_pkg::ST_OVER;
              time_up_d = 1'b1;
            end
          end
        end
        game_pkg::ST_PAUSE: begin
          if (start) state_d = game_pkg::ST_RUN;
        end
        game_pkg::ST_OVER: begin
          // terminal: only clear leaves this state
        end
        default: state_d = game_pkg::ST_IDLE;
      endcase
    end
    running_d = (state_d == game_pkg::ST_RUN);
  end

  // State, count, digits and flag outputs, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= game_pkg::ST_IDLE;
      sec_q     <= '0;
      bcd_q     <= '0;
      running_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      bcd_q     <= bcd_d;
      running_q <= running_d;
      time_up_q <= time_up_d;
    end
  end

  assign sec     = sec_q;
  assign bcd_h   = bcd_q.h;
  assign bcd_t   = bcd_q.t;
  assign bcd_o   = bcd_q.o;
  assign state   = state_q;
  assign running = running_q;
  assign time_up = time_up_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: a default instance (MAX_SEC=180) and a
// short-game instance (MAX_SEC=5) share all inputs.
module tb_game_timer;
  import game_pkg::*;

  localparam int W = game_pkg::SEC_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_1hz = 1'b0;
  logic         start = 1'b0, pause = 1'b0, clear = 1'b0;

  logic [W-1:0] sec,  sec5;
  logic [3:0]   bh, bt, bo, bh5, bt5, bo5;
  logic [1:0]   st, st5;
  logic         run, run5, tu, tu5;

  int checks = 0;
  int failures = 0;

  int          exp_sec = 0;
  game_state_e exp_st  = ST_IDLE;

  always #5 clk = ~clk;

  game_timer dut (
    .clk(clk), .rst(rst_n), .clk_1hz(clk_1hz), .start(start), .pause(pause),
    .clear(clear), .sec(sec), .bcd_h(bh), .bcd_t(bt), .bcd_o(bo), .state(st),
    .running(run), .time_up(tu)
  );

  game_timer #(.SEC_W(W), .MAX_SEC(5)) dut5 (
    .clk(clk), .rst(rst_n), .clk_1hz(clk_1hz), .start(start), .pause(pause),
    .clear(clear), .sec(sec5), .bcd_h(bh5), .bcd_t(bt5), .bcd_o(bo5), .state(st5),
    .running(run5), .time_up(tu5)
  );

  // time_up watcher for the short-game instance: counts pulses and flags any
  // pulse not in the first cycle of OVER (previous state RUN).
  int       tu_cnt = 0, tu_bad = 0;
  logic [1:0] st5_prev = 2'b00;
  always @(negedge clk) begin
    if (tu5) begin
      tu_cnt <= tu_cnt + 1;
      if (st5 != ST_OVER || st5_prev != ST_RUN) tu_bad <= tu_bad + 1;
    end
    st5_prev <= st5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Compare every main-instance output with the bench model.
  task automatic chk_all(input string tag);
    chk({tag, ".sec"},     32'(sec), 32'(exp_sec));
    chk({tag, ".bcd_h"},   32'(bh),  32'(exp_sec / 100));
    chk({tag, ".bcd_t"},   32'(bt),  32'((exp_sec / 10) % 10));
    chk({tag, ".bcd_o"},   32'(bo),  32'(exp_sec % 10));
    chk({tag, ".state"},   32'(st),  32'(exp_st));
    chk({tag, ".running"}, 32'(run), 32'(exp_st == ST_RUN));
    chk({tag, ".time_up"}, 32'(tu),  32'd0);
  endtask

  // One clk_1hz period; the count must still be old after 2 edges and new after 3.
  task automatic do_tick(input string tag);
    clk_1hz = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk({tag, ".pre"}, 32'(sec), 32'(exp_sec));
    @(posedge clk); #1;
    if (exp_st == ST_RUN) exp_sec++;
    chk_all(tag);
    clk_1hz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic ticks_to(input int target);
    while (exp_sec < target) do_tick("run");
  endtask

  // Drive the given control pulses for exactly one clock edge.
  task automatic pulse(input bit c, input bit p, input bit s);
    clear = c; pause = p; start = s;
    @(posedge clk); #1;
    clear = 1'b0; pause = 1'b0; start = 1'b0;
  endtask

  int tu0, bad0;

  initial begin
    // reset state
    repeat (2) @(posedge clk); #1;
    chk_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset");

    // start, then 12 ticks with edge-accurate latency
    pulse(0, 0, 1); exp_st = ST_RUN;
    chk_all("start");
    ticks_to(12);
    chk_all("sec12");

    // reset mid-count at 57: outputs clear before the next edge
    ticks_to(57);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp_sec = 0; exp_st = ST_IDLE;
    chk_all("async_reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_tick("idle_after_reset");

    // 9 -> 10 boundary
    pulse(0, 0, 1); exp_st = ST_RUN;
    ticks_to(9);
    do_tick("carry_9_10");
    chk("carry_9_10.t", 32'(bt), 32'd1);

    // pause at 20, ticks ignored, resume
    ticks_to(20);
    pulse(0, 1, 0); exp_st = ST_PAUSE;
    chk_all("paused");
    repeat (5) do_tick("paused_tick");
    chk("paused.sec", 32'(sec), 32'd20);
    pulse(0, 0, 1); exp_st = ST_RUN;
    do_tick("resume");
    chk("resume.sec", 32'(sec), 32'd21);

    // pause in the same cycle the tick is seen -> tick lost
    clk_1hz = 1'b1;
    repeat (2) @(posedge clk); #1;
    pause = 1'b1;
    @(posedge clk); #1;
    pause = 1'b0; exp_st = ST_PAUSE;
    chk_all("pause_tick_same");
    clk_1hz = 1'b0;
    repeat (3) @(posedge clk); #1;
    pulse(0, 0, 1); exp_st = ST_RUN;

    // 99 -> 100 boundary
    ticks_to(99);
    chk_all("sec99");
    do_tick("carry_99_100");
    chk("carry_99_100.h", 32'(bh), 32'd1);

    // clear + pause + start together in RUN: clear wins
    pulse(1, 1, 1); exp_sec = 0; exp_st = ST_IDLE;
    chk_all("clear_wins");
    do_tick("idle_tick");

    // short game: terminal count 5, single time_up pulse, start ignored in OVER
    tu0 = tu_cnt; bad0 = tu_bad;
    pulse(0, 0, 1); exp_st = ST_RUN;
    repeat (7) do_tick("short_run");
    chk("short.tu_count", 32'(tu_cnt - tu0), 32'd1);
    chk("short.tu_timing", 32'(tu_bad - bad0), 32'd0);
    chk("short.state", 32'(st5), 32'(ST_OVER));
    chk("short.sec", 32'(sec5), 32'd5);
    chk("short.bcd_o", 32'(bo5), 32'd5);
    chk("short.running", 32'(run5), 32'd0);
    pulse(0, 0, 1);
    chk("short.start_ignored.state", 32'(st5), 32'(ST_OVER));
    chk("short.start_ignored.sec", 32'(sec5), 32'd5);
    pulse(1, 0, 0); exp_sec = 0; exp_st = ST_IDLE;
    chk("short.clear.state", 32'(st5), 32'(ST_IDLE));
    chk("short.clear.sec", 32'(sec5), 32'd0);
    chk("short.clear.tu", 32'(tu5), 32'd0);
    chk_all("final_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
